// File: rtl/list_sort_ctrl.sv
// In-place ascending bubble sort of RAM words 0..len-1 over a single-port synchronous-read RAM.
// Latency 4 cycles per compared pair (+2 on swap); no backpressure, start is ignored while busy.
module list_sort_ctrl #(
    parameter int WIDTH = 32,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    len,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rd_en,
    input  logic [WIDTH-1:0] mem_rd_data,
    output logic             mem_wr_en,
    output logic [WIDTH-1:0] mem_wr_data,
    output logic [31:0]      swaps,
    output logic [AW-1:0]    passes
);

    typedef enum logic [2:0] {IDLE, RD0, RD1, CMP, WR0, WR1, ADV, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   len_q, len_d;
    logic [AW-1:0]   i_q, i_d;
    logic [AW-1:0]   j_q, j_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic            swapped_q, swapped_d;
    logic [31:0]     swaps_q, swaps_d;
    logic [AW-1:0]   passes_q, passes_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic            rd_en, wr_en;

    // One extra bit so the pass-end arithmetic cannot wrap.
    logic [AW:0] j_nxt, pass_lim;
    logic        last_pass;

    assign j_nxt     = {1'b0, j_q} + (AW+1)'(1);
    assign pass_lim  = {1'b0, len_q} - {1'b0, i_q} - (AW+1)'(1);
    assign last_pass = ({1'b0, i_q} + (AW+1)'(2)) == {1'b0, len_q};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        i_d       = i_q;
        j_d       = j_q;
        a_d       = a_q;
        b_d       = b_q;
        swapped_d = swapped_q;
        swaps_d   = swaps_q;
        passes_d  = passes_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    swaps_d = '0;
                    if (len >= AW'(2)) begin
                        i_d       = '0;
                        j_d       = '0;
                        swapped_d = 1'b0;
                        passes_d  = AW'(1);
                        state_d   = RD0;
                    end else begin
                        passes_d = '0;
                        state_d  = DONE;
                    end
                end
            end
            RD0: begin
                rd_en   = 1'b1;
                addr_d  = j_q;
                state_d = RD1;
            end
            RD1: begin
                rd_en   = 1'b1;
                addr_d  = j_q + AW'(1);
                a_d     = mem_rd_data;
                state_d = CMP;
            end
            CMP: begin
                b_d     = mem_rd_data;
                state_d = (a_q > mem_rd_data) ? WR0 : ADV;
            end
            WR0: begin
                wr_en   = 1'b1;
                addr_d  = j_q;
                wdata_d = b_q;
                state_d = WR1;
            end
            WR1: begin
                wr_en     = 1'b1;
                addr_d    = j_q + AW'(1);
                wdata_d   = a_q;
                swaps_d   = swaps_q + 32'd1;
                swapped_d = 1'b1;
                state_d   = ADV;
            end
            ADV: begin
                if (j_nxt < pass_lim) begin
                    j_d     = j_q + AW'(1);
                    state_d = RD0;
                end else if (!swapped_q || last_pass) begin
                    state_d = DONE;
                end else begin
                    i_d       = i_q + AW'(1);
                    passes_d  = passes_q + AW'(1);
                    j_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = RD0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            swapped_q <= 1'b0;
            swaps_q   <= '0;
            passes_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            i_q       <= i_d;
            j_q       <= j_d;
            a_q       <= a_d;
            b_q       <= b_d;
            swapped_q <= swapped_d;
            swaps_q   <= swaps_d;
            passes_q  <= passes_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Address/data are driven combinationally in the access cycle and held otherwise.
    assign mem_addr    = addr_d;
    assign mem_wr_data = wdata_d;
    assign mem_rd_en   = rd_en;
    assign mem_wr_en   = wr_en;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign swaps       = swaps_q;
    assign passes      = passes_q;

endmodule

// File: tb/tb_list_sort_ctrl.sv
// Randomized and directed bench for list_sort_ctrl against a plain bubble-sort model.
module tb_list_sort_ctrl;
    localparam int WIDTH = 32;
    localparam int AW    = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    len;
    logic             busy, done;
    logic [AW-1:0]    mem_addr;
    logic             mem_rd_en, mem_wr_en;
    logic [WIDTH-1:0] mem_rd_data;
    logic [WIDTH-1:0] mem_wr_data;
    logic [31:0]      swaps;
    logic [AW-1:0]    passes;

    list_sort_ctrl #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .swaps(swaps), .passes(passes)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] ram  [0:1023];
    logic [WIDTH-1:0] vals [0:31];
    logic             ld_en;
    logic [AW-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_dat;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
        if (ld_en) ram[ld_addr] <= ld_dat;
        else if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
    end

    int checks = 0, passed = 0;
    int viol = 0, n_rd = 0, n_wr = 0, n_done = 0;
    int cur_len = 0;
    logic [AW-1:0]    prev_addr;
    logic [WIDTH-1:0] prev_wdata;

    // Bus-protocol monitor: exclusive strobes, in-range addresses, held address/data when idle.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en && mem_wr_en) viol++;
            if ((mem_rd_en || mem_wr_en) && int'(mem_addr) >= cur_len) viol++;
            if (!mem_rd_en && !mem_wr_en && (mem_addr !== prev_addr || mem_wr_data !== prev_wdata)) viol++;
            if (mem_rd_en) n_rd++;
            if (mem_wr_en) n_wr++;
            if (done) n_done++;
        end
        prev_addr  = mem_addr;
        prev_wdata = mem_wr_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n);
        for (int k = 0; k < n; k++) begin
            ld_en = 1'b1; ld_addr = AW'(k); ld_dat = vals[k];
            tick();
        end
        ld_en = 1'b0;
    endtask

    task automatic run_sort(input int n, input string tag, input bit do_load, input bit poke);
        logic [WIDTH-1:0] m [0:31];
        logic [WIDTH-1:0] t;
        int exp_sw, exp_ps, exp_cyc, cyc, rd0, wr0, dn0, v0, bad;
        bit sw;
        if (do_load) load(n);
        for (int k = 0; k < 32; k++) m[k] = vals[k];
        exp_sw = 0; exp_ps = 0; exp_cyc = 1;
        for (int i = 0; i < n - 1; i++) begin
            exp_ps = i + 1;
            sw = 0;
            for (int j = 0; j < n - 1 - i; j++) begin
                exp_cyc += 4;
                if (m[j] > m[j+1]) begin
                    t = m[j]; m[j] = m[j+1]; m[j+1] = t;
                    exp_sw++; sw = 1; exp_cyc += 2;
                end
            end
            if (!sw) break;
        end
        cur_len = n;
        rd0 = n_rd; wr0 = n_wr; dn0 = n_done; v0 = viol;
        start = 1'b1; len = AW'(n);
        tick();
        start = 1'b0; len = AW'($urandom_range(0, 1023));
        cyc = 1;
        while (!done && cyc < 5000) begin
            tick();
            cyc++;
            if (!done && poke) begin
                start = 1'($urandom_range(0, 1));
                len = AW'($urandom_range(0, 1023));
            end
        end
        start = 1'b0;
        checks++; if (cyc !== exp_cyc) $display("FAIL %s done_cycle got %0d want %0d", tag, cyc, exp_cyc); else passed++;
        repeat (3) tick();
        checks++; if (n_done - dn0 !== 1) $display("FAIL %s done_pulses got %0d want 1", tag, n_done - dn0); else passed++;
        checks++; if (swaps !== 32'(exp_sw)) $display("FAIL %s swaps got %0d want %0d", tag, swaps, exp_sw); else passed++;
        checks++; if (passes !== AW'(exp_ps)) $display("FAIL %s passes got %0d want %0d", tag, passes, exp_ps); else passed++;
        bad = 0;
        for (int k = 0; k < n; k++) if (ram[k] !== m[k]) bad++;
        checks++; if (bad != 0) $display("FAIL %s ram_contents got %0d wrong words want 0", tag, bad); else passed++;
        checks++; if (n_wr - wr0 !== 2 * exp_sw) $display("FAIL %s writes got %0d want %0d", tag, n_wr - wr0, 2 * exp_sw); else passed++;
        checks++; if (n_rd - rd0 !== 2 * ((exp_cyc - 1 - 6 * exp_sw) / 4 + exp_sw))
            $display("FAIL %s reads got %0d want %0d", tag, n_rd - rd0, 2 * ((exp_cyc - 1 - 6 * exp_sw) / 4 + exp_sw));
        else passed++;
        checks++; if (viol - v0 !== 0) $display("FAIL %s bus_protocol got %0d violations want 0", tag, viol - v0); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL %s busy_after got %b want 0", tag, busy); else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; ld_en = 1'b0; ld_addr = '0; ld_dat = '0;
        repeat (3) tick();
        checks++; if ({busy, done, mem_rd_en, mem_wr_en} !== 4'b0) $display("FAIL reset_ctrl got %b want 0000", {busy, done, mem_rd_en, mem_wr_en}); else passed++;
        checks++; if (mem_addr !== '0 || mem_wr_data !== '0) $display("FAIL reset_bus got addr=%0d data=%0d want 0/0", mem_addr, mem_wr_data); else passed++;
        checks++; if (swaps !== '0 || passes !== '0) $display("FAIL reset_counts got swaps=%0d passes=%0d want 0/0", swaps, passes); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        vals[0] = 5; vals[1] = 3;
        run_sort(2, "pair_swap", 1, 0);
        vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 4;
        run_sort(4, "sorted4", 1, 0);
        vals[0] = 4; vals[1] = 3; vals[2] = 2; vals[3] = 1;
        run_sort(4, "reverse4", 1, 0);
        vals[0] = 7; vals[1] = 7; vals[2] = 7;
        run_sort(3, "equal3", 1, 0);
        run_sort(1, "len1", 1, 0);
        run_sort(0, "len0", 0, 0);
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(2, 16);
            for (int k = 0; k < n; k++)
                vals[k] = (r % 2 == 0) ? WIDTH'($urandom_range(0, 5)) : $urandom;
            run_sort(n, $sformatf("random%0d", r), 1, 0);
        end
    endtask

    task automatic test_start_while_busy();
        for (int k = 0; k < 10; k++) vals[k] = $urandom;
        run_sort(10, "start_while_busy", 1, 1);
    endtask

    task automatic test_reset_mid_write();
        int c;
        vals[0] = 9; vals[1] = 1; vals[2] = 8; vals[3] = 2; vals[4] = 7; vals[5] = 3;
        load(6);
        cur_len = 6;
        start = 1'b1; len = AW'(6);
        tick();
        start = 1'b0;
        c = 0;
        while (!(mem_wr_en && swaps == 32'd1) && c < 500) begin tick(); c++; end
        checks++; if (c >= 500) $display("FAIL midwr_reach got timeout want second swap WR0"); else passed++;
        rst = 1'b1;
        #1;
        checks++; if ({busy, mem_wr_en, mem_rd_en} !== 3'b0) $display("FAIL midwr_abort got busy/wr/rd=%b want 000", {busy, mem_wr_en, mem_rd_en}); else passed++;
        checks++; if (swaps !== '0 || passes !== '0) $display("FAIL midwr_counts got swaps=%0d passes=%0d want 0/0", swaps, passes); else passed++;
        tick();
        load(6);
        rst = 1'b0;
        run_sort(6, "resort_after_reset", 0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/list_sort_ctrl.md
LIST_SORT_CTRL -- requirements
Module: list_sort_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the list element width in bits.
REQ-002 Parameter AW, default 10, SHALL set the RAM address width; it covers the 1000-entry list.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 start  input  1  SHALL be a sort request, sampled only in IDLE.
REQ-006 len  input  AW  SHALL be the element count, captured when start is accepted.
REQ-007 busy  output  1  SHALL be high in every state except IDLE.
REQ-008 done  output  1  SHALL be a one-cycle completion pulse.
REQ-009 mem_addr  output  AW  SHALL be the single-port RAM address.
REQ-010 mem_rd_en  output  1  SHALL be the RAM read strobe; mem_rd_data is valid the cycle after.
REQ-011 mem_rd_data  input  WIDTH  SHALL be the RAM read data.
REQ-012 mem_wr_en  output  1  SHALL be the RAM write strobe, one word per cycle.
REQ-013 mem_wr_data  output  WIDTH  SHALL be the RAM write data.
REQ-014 swaps  output  32  SHALL count the swaps performed in the current or last sort.
REQ-015 passes  output  AW  SHALL count the passes started in the current or last sort.

Function
REQ-016 The controller SHALL bubble-sort RAM words 0..len-1 into ascending unsigned order, in place.
REQ-017 The FSM SHALL have the states IDLE, RD0, RD1, CMP, WR0, WR1, ADV and DONE.
REQ-018 In IDLE, start=1 with len>=2 SHALL set: pass i=0, index j=0, swapped=0, swaps=0, passes=1; next state RD0.
REQ-019 In IDLE, start=1 with len<2 SHALL set swaps=0 and passes=0 and go to DONE, with no RAM access.
REQ-020 RD0 SHALL drive rd_en=1 and addr=j, then go to RD1.
REQ-021 RD1 SHALL drive rd_en=1 and addr=j+1, register A=mem_rd_data, then go to CMP.
REQ-022 CMP SHALL register B=mem_rd_data; if A>B (strict, unsigned) it SHALL go to WR0, otherwise to ADV.
REQ-023 WR0 SHALL drive wr_en=1, addr=j, wr_data=B, then go to WR1.
REQ-024 WR1 SHALL drive wr_en=1, addr=j+1, wr_data=A, increment swaps, set swapped=1, then go to ADV.
REQ-025 ADV, when j+1 < len-1-i, SHALL increment j and go to RD0.
REQ-026 ADV at pass end (j+1 = len-1-i) SHALL go to DONE if swapped=0 or i+1=len-1.
REQ-027 ADV at pass end otherwise SHALL increment i and passes, clear j and swapped, and go to RD0.
REQ-028 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-029 Per-pair latency SHALL be 4 cycles without a swap and 6 cycles with a swap.
REQ-030 Equal elements SHALL never be swapped.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 len SHALL be sampled only at acceptance; later changes SHALL have no effect.
REQ-033 rd_en and wr_en SHALL never be high in the same cycle.
REQ-034 No RAM access SHALL be made at an address >= the captured len.
REQ-035 When rd_en=0 and wr_en=0, mem_addr and mem_wr_data SHALL hold their previous values.
REQ-036 swaps and passes SHALL hold their values after DONE until the next accepted start.

Reset
REQ-037 rst=1 SHALL immediately set the state to IDLE and zero the registers and outputs: busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, swaps, passes, i, j, A, B, swapped.
REQ-038 Reset during WR0/WR1 SHALL abort the swap with no further write; the RAM contents are then undefined as a sorted list.
REQ-039 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-040 len=2, RAM={5,3}, start -> writes (0,3) then (1,5); swaps=1, passes=1; done exactly once.
REQ-041 len=4, RAM={1,2,3,4}, start in cycle 0 -> done in cycle 13; no writes; swaps=0, passes=1.
REQ-042 len=4, RAM={4,3,2,1} -> RAM={1,2,3,4}, swaps=6, passes=3.
REQ-043 len=3, RAM={7,7,7} -> no writes; swaps=0, passes=1.
REQ-044 len=1 or len=0 -> done in the cycle after start; no rd_en/wr_en; swaps=0, passes=0.
REQ-045 rst pulse while in WR0 mid-sort -> next cycle busy=0, wr_en=0, swaps=0; a subsequent start re-sorts correctly.
